// File: rtl/latch_sr_gated_if.sv
// Set/reset request and stored-value bundle for the gated SR latch bank.
//   s, r         : per-bit set / clear requests (driven by master)
//   q, qn        : stored value and its complement (driven by slave)
//   invalid      : per-bit forbidden-combination indicator (LATCH_SR_INVALID_FLAG_EN only)
//   invalid_seen : sticky forbidden-combination flag (LATCH_SR_INVALID_FLAG_EN only)
interface latch_sr_gated_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
`ifdef LATCH_SR_INVALID_FLAG_EN
  logic [WIDTH-1:0] invalid;
  logic             invalid_seen;

  modport master (output s, r, input q, qn, invalid, invalid_seen);
  modport slave  (input s, r, output q, qn, invalid, invalid_seen);
`else
  modport master (output s, r, input q, qn);
  modport slave  (input s, r, output q, qn);
`endif
endinterface

// File: rtl/latch_sr_gated.sv
// Level-sensitive gated SR latch bank: WIDTH independent slices sharing one
// gate (clk) and one reset. Transparent while clk=1, holds while clk=0.
// Optional feature macro: LATCH_SR_INVALID_FLAG_EN (adds invalid/invalid_seen).
// Ports:
//   clk : gate; transparent when 1
//   rst : active-high reset, honoured only while the gate is open
//   bus : latch_sr_gated_if.slave (s, r in; q, qn out)
module latch_sr_gated #(
  parameter int unsigned     WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  latch_sr_gated_if.slave    bus
);

  logic [WIDTH-1:0] q_lat;

  // Storage latch; set+clear together leaves the bit untouched.
  always_latch begin
    if (clk) begin
      if (rst) begin
        q_lat <= RESET_VAL;
      end else begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
          if (bus.s[i] && !bus.r[i]) begin
            q_lat[i] <= 1'b1;
          end else if (bus.r[i] && !bus.s[i]) begin
            q_lat[i] <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.q  = q_lat;
  assign bus.qn = ~q_lat;

`ifdef LATCH_SR_INVALID_FLAG_EN
  logic invalid_seen_lat;

  assign bus.invalid = {WIDTH{clk & ~rst}} & bus.s & bus.r;

  // Sticky flag, open only with the gate; cleared by reset.
  always_latch begin
    if (clk) begin
      if (rst) begin
        invalid_seen_lat <= 1'b0;
      end else if (|(bus.s & bus.r)) begin
        invalid_seen_lat <= 1'b1;
      end
    end
  end

  assign bus.invalid_seen = invalid_seen_lat;
`endif

endmodule

// File: tb/tb_latch_sr_gated.sv
// Scoreboard bench for latch_sr_gated (WIDTH=4): directed plan then random
// stimulus against a per-bit behavioural model.
module tb_latch_sr_gated;

  localparam int unsigned W = 4;
  localparam logic [W-1:0] RV = 4'b0000;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] known;
    logic [W-1:0] inv;
    logic         seen;
    logic         seen_known;
    string        tag;
  } exp_t;

  logic clk;
  logic rst;

  latch_sr_gated_if #(.WIDTH(W)) bus ();

  latch_sr_gated #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Behavioural model state: value per bit plus which bits are defined yet.
  bit [W-1:0] m_q;
  bit [W-1:0] m_known;
  bit         m_seen;
  bit         m_seen_known;

  // Apply inputs, let the latch settle, then queue the model's expectation.
  task automatic drive(input logic c, input logic rs, input logic [W-1:0] sv,
                       input logic [W-1:0] rv, input string tag);
    exp_t e;
    bit [W-1:0] inv;
    clk   = c;
    rst   = rs;
    bus.s = sv;
    bus.r = rv;
    inv   = '0;
    if (c) begin
      if (rs) begin
        m_q          = RV;
        m_known      = '1;
        m_seen       = 1'b0;
        m_seen_known = 1'b1;
      end else begin
        for (int i = 0; i < int'(W); i++) begin
          case ({sv[i], rv[i]})
            2'b10: begin m_q[i] = 1'b1; m_known[i] = 1'b1; end
            2'b01: begin m_q[i] = 1'b0; m_known[i] = 1'b1; end
            2'b11: inv[i] = 1'b1;
            default: ;
          endcase
        end
        if (inv != 0) m_seen = 1'b1;
      end
    end
    #1;
    e.q = m_q; e.known = m_known; e.inv = inv;
    e.seen = m_seen; e.seen_known = m_seen_known; e.tag = tag;
    exp_q.push_back(e);
    #2;
  endtask

  // Monitor: pops one expectation per settled stimulus and compares.
  initial begin
    exp_t e;
    forever begin
      wait (exp_q.size() > 0);
      #1;
      e = exp_q.pop_front();
      if (e.known != 0) begin
        n_checks++;
        if ((bus.q & e.known) !== (e.q & e.known)) begin
          n_fail++;
          $display("FAIL %s q: got %b expected %b (mask %b) at %0t", e.tag, bus.q, e.q, e.known, $time);
        end
        n_checks++;
        if ((bus.qn & e.known) !== (~e.q & e.known)) begin
          n_fail++;
          $display("FAIL %s qn: got %b expected %b (mask %b) at %0t", e.tag, bus.qn, ~e.q, e.known, $time);
        end
      end
`ifdef LATCH_SR_INVALID_FLAG_EN
      n_checks++;
      if (bus.invalid !== e.inv) begin
        n_fail++;
        $display("FAIL %s invalid: got %b expected %b at %0t", e.tag, bus.invalid, e.inv, $time);
      end
      if (e.seen_known) begin
        n_checks++;
        if (bus.invalid_seen !== e.seen) begin
          n_fail++;
          $display("FAIL %s invalid_seen: got %b expected %b at %0t", e.tag, bus.invalid_seen, e.seen, $time);
        end
      end
`endif
    end
  end

  initial begin
    logic [W-1:0] sv, rv;
    m_q = '0; m_known = '0; m_seen = 1'b0; m_seen_known = 1'b0;
    clk = 1'b0; rst = 1'b0; bus.s = '0; bus.r = '0;
    #5;

    // Reset dominates set; then release with gate closed.
    drive(1, 1, 4'b0001, 4'b0000, "reset");
    drive(0, 1, 4'b0001, 4'b0000, "reset_close");
    drive(0, 0, 4'b0000, 4'b0000, "reset_release");
    // Set while closed has no effect; opening captures it; clear while closed ignored.
    drive(0, 0, 4'b0001, 4'b0000, "set_closed");
    drive(1, 0, 4'b0001, 4'b0000, "set_open");
    drive(0, 0, 4'b0000, 4'b0001, "clr_closed");
    // Clear then hold.
    drive(1, 0, 4'b0000, 4'b0001, "clear");
    drive(1, 0, 4'b0000, 4'b0000, "clear_hold");
    // Forbidden combination holds previous value.
    drive(1, 0, 4'b0001, 4'b0000, "forb_pre");
    drive(1, 0, 4'b0001, 4'b0001, "forbidden");
    drive(0, 0, 4'b0000, 4'b0000, "forb_close");
    drive(1, 0, 4'b0000, 4'b0000, "forb_reopen");
    // Transparency: pulses propagate immediately, last value retained.
    drive(1, 0, 4'b0001, 4'b0000, "trans_set");
    drive(1, 0, 4'b0000, 4'b0001, "trans_clr");
    drive(1, 0, 4'b0000, 4'b0000, "trans_idle");
    drive(0, 0, 4'b0000, 4'b0000, "trans_close");
    // Multi-bit patterns and reset gated by clk.
    drive(1, 0, 4'b0000, 4'b0010, "mb_prep0");
    drive(1, 0, 4'b0010, 4'b0000, "mb_prep1");
    drive(1, 0, 4'b0101, 4'b0010, "mb_write");
    drive(0, 0, 4'b0000, 4'b0000, "mb_close");
    drive(0, 1, 4'b0000, 4'b0000, "mb_rst_closed");
    drive(1, 1, 4'b0000, 4'b0000, "mb_rst_open");
    // Gate closes while new requests arrive in the same step: not captured.
    drive(1, 0, 4'b1010, 4'b0000, "close_pre");
    drive(0, 0, 4'b0101, 4'b1010, "close_race");
    // Mixed per-bit forbidden/set/clear.
    drive(1, 0, 4'b1100, 4'b1010, "mixed");

    for (int k = 0; k < 400; k++) begin
      sv = W'($urandom);
      rv = W'($urandom);
      if ($urandom_range(0, 3) == 0) rv = sv;
      drive(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 11) == 0), sv, rv, "random");
    end

    for (int k = 0; k < 100 && exp_q.size() != 0; k++) #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/latch_sr_gated.md
Name:
latch_sr_gated

Overview:
- Level-sensitive gated SR latch bank. `clk` is the gate (enable): the latch is transparent to set/reset commands while `clk`=1 and holds while `clk`=0.
- Used as a small storage/flag element in the datapath.
- `WIDTH` independent bit-slices share one gate and one reset.

Parameters:
- WIDTH, 1, number of independent SR bit-slices.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into `q` by reset.

Ports:
- clk  input  1  gate/enable; transparent when 1, opaque when 0 (the single clock of the block).
- rst  input  1  reset, synchronous (honoured only while `clk`=1), active-high.
- s  input  WIDTH  per-bit set request.
- r  input  WIDTH  per-bit reset (clear) request.
- q  output  WIDTH  stored value.
- qn  output  WIDTH  always ~q; never equal to `q`.

Behaviour:
- State is one WIDTH-bit register `q`; `qn` = ~`q` combinationally at all times.
- Gate closed (`clk`=0):
  - `q` holds.
  - Changes on `s`, `r` and `rst` have no effect.
- Gate open (`clk`=1), evaluated continuously (level-sensitive, zero cycle latency; `q` settles within the same delta/combinational path):
  - `rst`=1: `q` = RESET_VAL for all bits. Reset dominates `s` and `r`.
  - `rst`=0, per bit i:
    - s=0, r=0 -> hold.
    - s=0, r=1 -> q[i]=0.
    - s=1, r=0 -> q[i]=1.
    - s=1, r=1 -> forbidden combination; q[i] holds its previous value (decided policy; no oscillation, no X).
- Transparency: while `clk`=1, any change of `s`/`r` propagates immediately. The value present when `clk` falls is retained.
- Closing the gate (1->0) while `s`/`r` change in the same delta: the post-change `s`/`r` are not captured. Only values present while `clk`=1 matter.
- Power-up: `q` is unknown until the first reset or the first set/clear with the gate open. The bench must not check `q` before that.
- Reset mid-operation: asserting `rst` while the gate is open forces RESET_VAL immediately. Asserting `rst` while the gate is closed has no effect until `clk` rises with `rst` still high.
- Each bit-slice is independent. Forbidden-combination handling on one bit does not affect other bits.
- Implementation: one always block sensitive to `clk`, `rst`, `s`, `r` with incomplete assignment (intentional latch inference), or equivalent cross-coupled gating. No edge-triggered flops.

Optional Feature:
- Macro: LATCH_SR_INVALID_FLAG_EN.
- Defined:
  - Extra output port `invalid` [WIDTH], per-bit = clk & ~rst & s[i] & r[i] (combinational).
  - Extra output `invalid_seen` (1 bit), sticky OR of `invalid` while the gate is open; cleared only by `rst` with `clk`=1.
- Undefined:
  - Neither port exists.
  - Forbidden combination is silently treated as hold.

Test Plan:
- Reset: clk=1, rst=1, s=1, r=0 -> q=RESET_VAL (0), qn=1; drop clk, then rst=0 -> q stays 0.
- Set/hold: clk=0 s=1 r=0 -> q unchanged (0); clk=1 -> q=1; clk=0, s=0 r=1 -> q stays 1.
- Clear: q=1, clk=1 s=0 r=1 -> q=0, qn=1; clk=1 s=0 r=0 -> q stays 0.
- Forbidden: q=1, clk=1 s=1 r=1 -> q stays 1 (and with LATCH_SR_INVALID_FLAG_EN: invalid=1, invalid_seen=1); then clk=0 s=0 r=0, clk=1 -> q=1, invalid=0, invalid_seen stays 1.
- Transparency: clk=1 held; s pulses 1 then r pulses 1 -> q goes 1 then 0 immediately; clk falls with s=r=0 -> q=0 retained.
- Multi-bit (WIDTH=4): clk=1 s=4'b0101 r=4'b0010 from q=4'b0010 -> q=4'b0101; rst=1 with clk=0 -> q unchanged; clk=1 -> q=4'b0000.
